// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM states
// and byte-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  // funct3[1:0] is the access size; 011/110/111 have no legal size.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_LB, F3_LBU: is_misaligned = 1'b0;
      F3_LH, F3_LHU: is_misaligned = off[0];
      F3_LW:         is_misaligned = (off != 2'b00);
      default:       is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] wd);
    case (funct3[1:0])
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data alignment and sign/zero extension from a 32-bit
// bus word, byte offset and RV32 load funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'b0, shifted[7:0]};
      F3_LHU:  data = {16'b0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs loads/stores over a req/gnt/rvalid bus and registers
// the MEM/WB outputs, stalling earlier stages while a transfer is open.
//
// state | meaning
// IDLE  | no transfer; non-memops flow through in one cycle
// REQ   | mem_req_o held with stable controls until mem_gnt_i
// WAIT  | request granted, waiting for mem_rvalid_i
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RegWriteM_i,
  input  logic                      ResultSrcM_i,
  input  logic                      MemWriteM_i,
  input  logic [2:0]                Funct3M_i,
  input  logic [DATA_WIDTH-1:0]     ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]     WriteDataM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [DATA_WIDTH-1:0]     PCPlus4M_i,
  output logic                      StallM_o,
  output logic                      MisalignM_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH-1:0]     mem_addr_o,
  output logic [3:0]                mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      RegWriteW_o,
  output logic                      ResultSrcW_o,
  output logic [DATA_WIDTH-1:0]     ALUResultW_o,
  output logic [DATA_WIDTH-1:0]     ReadDataW_o,
  output logic [REG_ADDR_WIDTH-1:0] RdW_o,
  output logic [DATA_WIDTH-1:0]     PCPlus4W_o
);

  mem_state_t                state;
  logic                      is_load, is_store, is_memop, misal;
  logic                      cap_load, cap_rsrc;
  logic [2:0]                cap_f3;
  logic [1:0]                cap_off;
  logic [REG_ADDR_WIDTH-1:0] cap_rd;
  logic [DATA_WIDTH-1:0]     cap_alu, cap_pc4, ext_data;

  assign is_load  = RegWriteM_i & ResultSrcM_i;
  assign is_store = MemWriteM_i;
  assign is_memop = is_load | is_store;
  assign misal    = is_misaligned(Funct3M_i, ALUResultM_i[1:0]);

  load_extend u_load_extend (
    .rdata  (mem_rdata_i),
    .offset (cap_off),
    .funct3 (cap_f3),
    .data   (ext_data)
  );

  always_comb begin
    StallM_o    = 1'b0;
    MisalignM_o = 1'b0;
    case (state)
      IDLE: begin
        StallM_o    = is_memop & ~misal;
        MisalignM_o = is_memop & misal;
      end
      REQ:     StallM_o = 1'b1;
      WAIT:    StallM_o = ~mem_rvalid_i;
      default: StallM_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
      cap_load     <= 1'b0;
      cap_rsrc     <= 1'b0;
      cap_f3       <= '0;
      cap_off      <= '0;
      cap_rd       <= '0;
      cap_alu      <= '0;
      cap_pc4      <= '0;
      RegWriteW_o  <= 1'b0;
      ResultSrcW_o <= 1'b0;
      ALUResultW_o <= '0;
      ReadDataW_o  <= '0;
      RdW_o        <= '0;
      PCPlus4W_o   <= '0;
    end else begin
      // Bubble by default; only a completed instruction overrides it.
      RegWriteW_o  <= 1'b0;
      ResultSrcW_o <= 1'b0;
      ALUResultW_o <= '0;
      ReadDataW_o  <= '0;
      RdW_o        <= '0;
      PCPlus4W_o   <= '0;
      case (state)
        IDLE: begin
          if (is_memop && !misal) begin
            state       <= REQ;
            mem_req_o   <= 1'b1;
            mem_we_o    <= is_store;
            mem_addr_o  <= {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};
            mem_be_o    <= lane_be(Funct3M_i, ALUResultM_i[1:0]);
            mem_wdata_o <= lane_wdata(Funct3M_i, WriteDataM_i);
            cap_load    <= is_load;
            cap_rsrc    <= ResultSrcM_i;
            cap_f3      <= Funct3M_i;
            cap_off     <= ALUResultM_i[1:0];
            cap_rd      <= RdM_i;
            cap_alu     <= ALUResultM_i;
            cap_pc4     <= PCPlus4M_i;
          end else if (!is_memop) begin
            RegWriteW_o  <= RegWriteM_i;
            ResultSrcW_o <= ResultSrcM_i;
            ALUResultW_o <= ALUResultM_i;
            RdW_o        <= RdM_i;
            PCPlus4W_o   <= PCPlus4M_i;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            state     <= WAIT;
            mem_req_o <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state        <= IDLE;
            RegWriteW_o  <= cap_load;
            ResultSrcW_o <= cap_rsrc;
            ALUResultW_o <= cap_alu;
            ReadDataW_o  <= cap_load ? ext_data : '0;
            RdW_o        <= cap_rd;
            PCPlus4W_o   <= cap_pc4;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with a simple bus responder.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM_i, ResultSrcM_i, MemWriteM_i;
  logic [2:0]  Funct3M_i;
  logic [31:0] ALUResultM_i, WriteDataM_i, PCPlus4M_i;
  logic [3:0]  RdM_i;
  logic        StallM_o, MisalignM_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        RegWriteW_o, ResultSrcW_o;
  logic [31:0] ALUResultW_o, ReadDataW_o, PCPlus4W_o;
  logic [3:0]  RdW_o;

  int n_cmp = 0;
  int n_err = 0;
  int stalls, reqs;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .RegWriteM_i(RegWriteM_i), .ResultSrcM_i(ResultSrcM_i), .MemWriteM_i(MemWriteM_i),
    .Funct3M_i(Funct3M_i), .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
    .RdM_i(RdM_i), .PCPlus4M_i(PCPlus4M_i),
    .StallM_o(StallM_o), .MisalignM_o(MisalignM_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .RegWriteW_o(RegWriteW_o), .ResultSrcW_o(ResultSrcW_o), .ALUResultW_o(ALUResultW_o),
    .ReadDataW_o(ReadDataW_o), .RdW_o(RdW_o), .PCPlus4W_o(PCPlus4W_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_m(input logic rw, input logic rsrc, input logic mw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] rd,
                       input logic [31:0] pc4);
    RegWriteM_i = rw; ResultSrcM_i = rsrc; MemWriteM_i = mw; Funct3M_i = f3;
    ALUResultM_i = alu; WriteDataM_i = wd; RdM_i = rd; PCPlus4M_i = pc4;
  endtask

  // Called at a negedge with a memop on the M inputs; returns after the
  // completing edge with the M inputs cleared to a nop.
  task automatic run_bus(input int gnt_dly, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic exp_we,
                         output int n_stall, output int n_req);
    bit gnt_prev, done;
    n_stall = 0; n_req = 0; gnt_prev = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      if (mem_req_o) begin
        n_req++;
        chk("req_addr", mem_addr_o, exp_addr);
        chk("req_be", {28'b0, mem_be_o}, {28'b0, exp_be});
        chk("req_wdata", mem_wdata_o, exp_wdata);
        chk("req_we", {31'b0, mem_we_o}, {31'b0, exp_we});
        if (n_req > gnt_dly) mem_gnt_i = 1'b1;
      end
      if (gnt_prev) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata; done = 1;
      end
      #1;
      if (StallM_o) n_stall++;
      if (cyc > 0) chk("bubble", {31'b0, RegWriteW_o}, 32'd0);
      gnt_prev = mem_gnt_i;
      step();
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    set_m(0, 0, 0, 3'b000, 32'h0, 32'h0, 4'd0, 32'h0);
    if (!done) chk("bus_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    set_m(0, 0, 0, 3'b000, 32'h0, 32'h0, 4'd0, 32'h0);
    step(); step();
    chk("rst_regwrite", {31'b0, RegWriteW_o}, 32'd0);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'b0, StallM_o}, 32'd0);
    chk("rst_alu", ALUResultW_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    rst = 1'b0;
    step();

    // ALU op: one-cycle pass-through
    set_m(1, 0, 0, 3'b000, 32'h1234, 32'h0, 4'd5, 32'h44);
    #1 chk("alu_stall", {31'b0, StallM_o}, 32'd0);
    step();
    chk("alu_regwrite", {31'b0, RegWriteW_o}, 32'd1);
    chk("alu_result", ALUResultW_o, 32'h1234);
    chk("alu_rd", {28'b0, RdW_o}, 32'd5);
    chk("alu_pc4", PCPlus4W_o, 32'h44);
    chk("alu_rdata", ReadDataW_o, 32'd0);
    set_m(0, 0, 0, 3'b000, 32'h0, 32'h0, 4'd0, 32'h0);

    // SW 0x100
    set_m(0, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 4'd0, 32'h48);
    run_bus(0, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1, stalls, reqs);
    chk("sw_stalls", stalls, 32'd2);
    chk("sw_reqs", reqs, 32'd1);
    chk("sw_regwrite", {31'b0, RegWriteW_o}, 32'd0);
    chk("sw_rdata", ReadDataW_o, 32'd0);
    chk("sw_pc4", PCPlus4W_o, 32'h48);

    // SB 0x102 data A5: lane 2, replicated
    set_m(0, 0, 1, 3'b000, 32'h102, 32'h000000A5, 4'd0, 32'h4C);
    run_bus(0, 32'h0, 32'h100, 4'b0100, 32'hA5A5A5A5, 1'b1, stalls, reqs);
    chk("sb_stalls", stalls, 32'd2);

    // LB 0x103 from 0x80FFFFFF
    set_m(1, 1, 0, 3'b000, 32'h103, 32'h0, 4'd7, 32'h50);
    run_bus(0, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h0, 1'b0, stalls, reqs);
    chk("lb_data", ReadDataW_o, 32'hFFFFFF80);
    chk("lb_regwrite", {31'b0, RegWriteW_o}, 32'd1);
    chk("lb_rsrc", {31'b0, ResultSrcW_o}, 32'd1);
    chk("lb_rd", {28'b0, RdW_o}, 32'd7);
    chk("lb_alu", ALUResultW_o, 32'h103);
    chk("lb_pc4", PCPlus4W_o, 32'h50);

    // LBU 0x103 from 0x80FFFFFF
    set_m(1, 1, 0, 3'b100, 32'h103, 32'h0, 4'd8, 32'h54);
    run_bus(0, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h0, 1'b0, stalls, reqs);
    chk("lbu_data", ReadDataW_o, 32'h00000080);

    // LH 0x202 with grant delayed 3 cycles
    set_m(1, 1, 0, 3'b001, 32'h202, 32'h0, 4'd9, 32'h58);
    run_bus(3, 32'h80011234, 32'h200, 4'b1100, 32'h0, 1'b0, stalls, reqs);
    chk("lh_reqs", reqs, 32'd4);
    chk("lh_stalls", stalls, 32'd5);
    chk("lh_data", ReadDataW_o, 32'hFFFF8001);
    chk("lh_rd", {28'b0, RdW_o}, 32'd9);

    // LHU 0x200
    set_m(1, 1, 0, 3'b101, 32'h200, 32'h0, 4'd10, 32'h5C);
    run_bus(1, 32'h8001F00D, 32'h200, 4'b0011, 32'h0, 1'b0, stalls, reqs);
    chk("lhu_data", ReadDataW_o, 32'h0000F00D);
    chk("lhu_stalls", stalls, 32'd3);

    // LW 0x104 word pass-through
    set_m(1, 1, 0, 3'b010, 32'h104, 32'h0, 4'd11, 32'h60);
    run_bus(0, 32'hCAFEF00D, 32'h104, 4'b1111, 32'h0, 1'b0, stalls, reqs);
    chk("lw_data", ReadDataW_o, 32'hCAFEF00D);

    // Misaligned LW 0x101, preceded by an ALU op so RegWriteW_o is 1 beforehand
    set_m(1, 0, 0, 3'b000, 32'h77, 32'h0, 4'd3, 32'h64);
    step();
    set_m(1, 1, 0, 3'b010, 32'h101, 32'h0, 4'd4, 32'h68);
    #1;
    chk("mis_pulse", {31'b0, MisalignM_o}, 32'd1);
    chk("mis_stall", {31'b0, StallM_o}, 32'd0);
    step();
    chk("mis_req", {31'b0, mem_req_o}, 32'd0);
    chk("mis_regwrite", {31'b0, RegWriteW_o}, 32'd0);
    set_m(1, 1, 0, 3'b001, 32'h203, 32'h0, 4'd4, 32'h6C);
    #1 chk("mis_lh", {31'b0, MisalignM_o}, 32'd1);
    set_m(1, 1, 0, 3'b011, 32'h0, 32'h0, 4'd4, 32'h6C);
    #1 chk("mis_f3", {31'b0, MisalignM_o}, 32'd1);
    set_m(0, 0, 0, 3'b000, 32'h0, 32'h0, 4'd0, 32'h0);
    #1 chk("mis_clear", {31'b0, MisalignM_o}, 32'd0);
    step();
    chk("mis_req2", {31'b0, mem_req_o}, 32'd0);

    // Reset while in WAIT, then a stray rvalid
    set_m(1, 1, 0, 3'b010, 32'h300, 32'h0, 4'd12, 32'h70);
    step();
    chk("rw_req", {31'b0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    #1 chk("rw_wait_stall", {31'b0, StallM_o}, 32'd1);
    rst = 1'b1;
    set_m(0, 0, 0, 3'b000, 32'h0, 32'h0, 4'd0, 32'h0);
    step();
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    #1 chk("rw_idle_stall", {31'b0, StallM_o}, 32'd0);
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    chk("rw_regwrite", {31'b0, RegWriteW_o}, 32'd0);
    chk("rw_rdata", ReadDataW_o, 32'd0);
    chk("rw_req_off", {31'b0, mem_req_o}, 32'd0);
    chk("rw_rd", {28'b0, RdW_o}, 32'd0);
    step();
    chk("rw_after", {31'b0, StallM_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage block that consumes the EX/MEM pipeline-register outputs.
- Executes loads and stores over a valid/grant/response data-bus handshake.
- Produces the registered MEM/WB pipeline outputs.
- Raises StallM_o so earlier stages hold while a bus transaction is outstanding.

Parameters:
DATA_WIDTH, 32, data/address width (fixed at 32 for byte-lane logic)
REG_ADDR_WIDTH, 4, destination register index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
RegWriteM_i  in  1  instruction writes a register
ResultSrcM_i  in  1  1 = result comes from memory (load)
MemWriteM_i  in  1  store
Funct3M_i  in  3  access size/sign (RV32 load/store funct3)
ALUResultM_i  in  DATA_WIDTH  effective address, or ALU result
WriteDataM_i  in  DATA_WIDTH  store data
RdM_i  in  REG_ADDR_WIDTH  destination register
PCPlus4M_i  in  DATA_WIDTH  PC+4
StallM_o  out  1  hold EX/MEM and earlier stages
MisalignM_o  out  1  one-cycle fault pulse
mem_req_o  out  1  bus request valid
mem_we_o  out  1  1 = write
mem_addr_o  out  DATA_WIDTH  word-aligned address
mem_be_o  out  4  byte enables
mem_wdata_o  out  DATA_WIDTH  lane-aligned write data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  response (read data or write ack)
mem_rdata_i  in  DATA_WIDTH  read data
RegWriteW_o  out  1  MEM/WB register write
ResultSrcW_o  out  1  MEM/WB result select
ALUResultW_o  out  DATA_WIDTH  MEM/WB ALU result
ReadDataW_o  out  DATA_WIDTH  extended load data
RdW_o  out  REG_ADDR_WIDTH  MEM/WB destination
PCPlus4W_o  out  DATA_WIDTH  MEM/WB PC+4

Behaviour:
- Definitions:
  - load = RegWriteM_i & ResultSrcM_i
  - store = MemWriteM_i
  - memop = load | store
- Misaligned:
  - halfword with addr[0] = 1
  - word with addr[1:0] != 0
  - funct3 in {011, 110, 111}
- Reset: state IDLE; all outputs 0, including every W register and mem_req_o. Reset mid-transaction drops mem_req_o on the next edge. An rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - non-memop: W registers capture the M inputs at the edge (1-cycle latency); ReadDataW_o = 0.
  - memop, aligned: StallM_o = 1 (combinational); capture addr/be/wdata/we, Rd, PC+4, ALUResult; go to REQ; W registers load a bubble (RegWriteW_o = 0).
  - memop, misaligned: MisalignM_o = 1 for this cycle; no bus request; W registers load a bubble; no stall.
- REQ:
  - mem_req_o = 1, with address/controls held stable until mem_gnt_i.
  - On gnt, go to WAIT. StallM_o = 1.
- WAIT:
  - mem_req_o = 0; StallM_o = !mem_rvalid_i.
  - On rvalid: W registers load the captured fields; ReadDataW_o = extended data for loads, 0 for stores; RegWriteW_o = captured load flag; return to IDLE. The pipeline advances on the same edge.
- Bubble: W registers hold RegWriteW_o = 0 during every stall cycle.
- Bus rules:
  - rvalid is never sampled outside WAIT.
  - Responders deliver rvalid no earlier than the cycle after gnt.
  - Minimum memop latency is 3 cycles (IDLE, REQ with gnt, WAIT with rvalid).
- Byte lanes (o = addr[1:0]):
  - Byte: be = 0001 << o; wdata = byte replicated ×4.
  - Half: be = 0011 << o; wdata = half replicated ×2.
  - Word: be = 1111.
  - mem_addr_o = {addr[31:2], 00}.
- Load extract: data = rdata >> (8·o), truncated to size.
  - funct3 000 / 001: sign-extend.
  - funct3 100 / 101: zero-extend.
  - funct3 010: data passed through.

Decomposition:
- Shared package mem_pkg:
  - funct3 size constants (F3_LB…F3_LHU, F3_SB/SH/SW)
  - mem_state_t enum {IDLE, REQ, WAIT}
- Sub-module load_extend: combinational rdata/offset/funct3 → extended data; reusable by a future cache.

Test Plan:
- ALU op (RegWriteM_i = 1, ALUResult = 0x1234, Rd = 5) -> next cycle RegWriteW_o = 1, ALUResultW_o = 0x1234, RdW_o = 5, StallM_o never high.
- SW addr 0x100, data 0xDEADBEEF; gnt in REQ, rvalid next cycle -> mem_be_o = 1111, mem_addr_o = 0x100, StallM_o high 2 cycles, RegWriteW_o = 0.
- LB addr 0x103, rdata 0x80FFFFFF -> mem_be_o = 1000, ReadDataW_o = 0xFFFFFF80. Same access as LBU -> ReadDataW_o = 0x00000080.
- LH addr 0x202 with gnt delayed 3 cycles -> mem_req_o and mem_addr_o = 0x200 stable for 4 cycles, stall lasts the whole wait, W registers bubble meanwhile.
- LW addr 0x101 -> MisalignM_o pulse, mem_req_o stays 0, no stall, RegWriteW_o = 0.
- rst asserted in WAIT, then rvalid -> state IDLE, outputs 0, rvalid ignored, RegWriteW_o stays 0.
